// File: rtl/pc_trace_capture.sv
// pc_trace_capture: trigger-based PC/data trace buffer with post-trigger capture and stepped readout.
// Define TRACE_DEDUP_EN to skip samples that repeat the last written PC.
module pc_trace_capture #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic [5:0]                SW,
  input  logic [DATA_W:1]           PC_In,
  input  logic [DATA_W:1]           Data_In,
  input  logic [DATA_W:1]           Trig_PC,
  output logic [DATA_W:1]           Trace_PC,
  output logic [DATA_W:1]           Trace_Data,
  output logic [2:1]                State,
  output logic [$clog2(DEPTH)+1:1]  Count,
  output logic [$clog2(DEPTH):1]    Rd_Idx,
  output logic                      Done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, PRE = 2'b01, POST = 2'b10, DONE = 2'b11} st_t;
  st_t state_q, state_d;
  logic clk, rst, arm, step_q, hit, capt, wr, arming, rise;
  logic [AW-1:0] wp_q, wp_d, rd_q, rd_d, post_q, post_d, raddr;
  logic [AW:0] cnt_q, cnt_d;
  logic [DATA_W:1] tpc_q, tpc_d, tdat_q, tdat_d;
  logic [DATA_W:1] pc_mem [DEPTH];
  logic [DATA_W:1] dat_mem [DEPTH];
  logic unused_sw;
  assign clk = SW[0];
  assign rst = SW[1];
  assign arm = SW[2];
  assign unused_sw = ^SW[5:4];
  assign hit = PC_In == Trig_PC;
  assign capt = (state_q == PRE || state_q == POST) && arm;
  assign arming = state_q == IDLE && arm;
  assign rise = SW[3] && !step_q;
`ifdef TRACE_DEDUP_EN
  logic first_q;
  logic [DATA_W:1] last_q;
  // the trigger sample is kept even when it repeats the previous PC
  assign wr = capt && (first_q || PC_In != last_q || (state_q == PRE && hit));
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b0;
      last_q  <= '0;
    end else begin
      first_q <= arming ? 1'b1 : wr ? 1'b0 : first_q;
      if (wr) last_q <= PC_In;
    end
  end
`else
  assign wr = capt;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arm ? PRE : IDLE;
      PRE:     state_d = !arm ? IDLE : hit ? (POST_TRIG == 0 ? DONE : POST) : PRE;
      POST:    state_d = !arm ? IDLE : (wr && post_q == AW'(1)) ? DONE : POST;
      default: state_d = !arm ? IDLE : DONE;
    endcase
  end
  always_comb begin
    State = state_q;
    Done  = state_q == DONE;
  end
  assign wp_d   = arming ? '0 : wr ? wp_q + AW'(1) : wp_q;
  assign cnt_d  = arming ? '0 : (wr && cnt_q != (AW+1)'(DEPTH)) ? cnt_q + (AW+1)'(1) : cnt_q;
  assign post_d = (state_q == PRE && capt && hit) ? AW'(POST_TRIG) :
                  (state_q == POST && wr) ? post_q - AW'(1) : post_q;
  // oldest entry sits Count slots behind the write pointer
  assign raddr  = wp_q - cnt_q[AW-1:0] + rd_q;
  assign rd_d   = state_d != DONE ? '0 :
                  (state_q == DONE && rise) ? (({1'b0, rd_q} == cnt_q - (AW+1)'(1)) ? '0 : rd_q + AW'(1)) : rd_q;
  assign tpc_d  = (state_q == DONE && state_d == DONE) ? pc_mem[raddr] : '0;
  assign tdat_d = (state_q == DONE && state_d == DONE) ? dat_mem[raddr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      cnt_q  <= '0;
      post_q <= '0;
      rd_q   <= '0;
      step_q <= 1'b0;
      tpc_q  <= '0;
      tdat_q <= '0;
    end else begin
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      post_q <= post_d;
      rd_q   <= rd_d;
      step_q <= SW[3];
      tpc_q  <= tpc_d;
      tdat_q <= tdat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wp_q]  <= PC_In;
      dat_mem[wp_q] <= Data_In;
    end
  end
  assign Count      = cnt_q;
  assign Rd_Idx     = rd_q;
  assign Trace_PC   = tpc_q;
  assign Trace_Data = tdat_q;
endmodule
